// File: rtl/bus_ram.sv
// bus_ram: word-organised on-chip RAM serving the core's single-master bus.
// One request is accepted at a time and answered by a one-cycle Ack, LATENCY
// edges after the accepting edge. Writes commit at the accepting edge, and
// reads sample the array into a read buffer at that same edge.
// Optional feature macro: MISALIGN_ERR_EN adds an Err output. When it is
// defined, requests with nonzero byte-offset bits are flagged and have no side
// effects.

`ifndef RAM_CAPACITY
`define RAM_CAPACITY 4096
`endif
`ifndef WORD_SIZE_B
`define WORD_SIZE_B 4
`endif

module bus_ram #(
  parameter int RAM_CAPACITY = `RAM_CAPACITY,
  parameter int WORD_SIZE_B  = `WORD_SIZE_B,
  parameter int LATENCY      = 2
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [$clog2(RAM_CAPACITY)-1:0] Addr,
  input  logic                            Cs,
  input  logic                            We,
  input  logic [8*WORD_SIZE_B-1:0]        Wdata,
  output logic [8*WORD_SIZE_B-1:0]        Rdata,
  output logic                            Ack
`ifdef MISALIGN_ERR_EN
  ,
  output logic                            Err
`endif
);

  localparam int ADDR_W = $clog2(RAM_CAPACITY);
  localparam int DATA_W = 8 * WORD_SIZE_B;
  localparam int OFF_W  = $clog2(WORD_SIZE_B);
  localparam int DEPTH  = RAM_CAPACITY / WORD_SIZE_B;
  localparam int IDX_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, DONE} state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic              we_q;
  logic              mis_q;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic              misaligned;
  logic              commit_write;

  assign word_idx = Addr[ADDR_W-1:OFF_W];
  assign accept   = Rst && (state == IDLE) && Cs;

`ifdef MISALIGN_ERR_EN
  assign misaligned = |Addr[OFF_W-1:0];
`else
  logic unused_offset;
  assign unused_offset = ^Addr[OFF_W-1:0];
  assign misaligned    = 1'b0;
`endif

  assign commit_write = accept && We && !misaligned;

  // Array port: writes commit and reads are buffered at the accepting edge.
  // The array itself is not cleared by reset.
  always_ff @(posedge Clk) begin
    if (commit_write)
      mem[word_idx] <= Wdata;
    if (accept && !We)
      rd_buf <= mem[word_idx];
  end

  // Transaction FSM with registered Ack/Rdata/Err.
  // Ack is raised on leaving ACK, so it is high LATENCY edges after the accept.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      Ack     <= 1'b0;
      Rdata   <= '0;
`ifdef MISALIGN_ERR_EN
      Err     <= 1'b0;
`endif
    end else begin
      Ack <= 1'b0;
`ifdef MISALIGN_ERR_EN
      Err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Cs) begin
            we_q    <= We;
            mis_q   <= misaligned;
            lat_cnt <= 4'(LATENCY - 1);
            state   <= (LATENCY == 1) ? ACK : BUSY;
          end
        end
        BUSY: begin
          lat_cnt <= 4'(lat_cnt - 4'd1);
          if (lat_cnt == 4'd1)
            state <= ACK;
        end
        ACK: begin
          Ack <= 1'b1;
          if (!we_q && !mis_q)
            Rdata <= rd_buf;
`ifdef MISALIGN_ERR_EN
          Err <= mis_q;
`endif
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: directed test of bus_ram (LATENCY=2, 4 KiB, 32-bit words).
// A transaction-level model predicts Ack/Rdata for every cycle and is
// compared on each falling edge. Literal expectations pin key results.

module tb_bus_ram;

  localparam int LAT = 2;

  logic        Clk;
  logic        Rst;
  logic [11:0] Addr;
  logic        Cs;
  logic        We;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        Ack;
`ifdef MISALIGN_ERR_EN
  logic        Err;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 0;

  bus_ram #(.RAM_CAPACITY(4096), .WORD_SIZE_B(4), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .Cs(Cs), .We(We),
    .Wdata(Wdata), .Rdata(Rdata), .Ack(Ack)
`ifdef MISALIGN_ERR_EN
    , .Err(Err)
`endif
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Transaction-level model: time is counted in edges, not FSM states.
  logic [31:0] model_mem [int];
  longint cyc = 0;
  longint next_accept = 0;
  longint ack_edge = 0;
  bit pending = 0;
  bit pend_we = 0;
  bit pend_mis = 0;
  logic [31:0] pend_data = '0;
  logic exp_ack = 0;
  logic exp_err = 0;
  logic [31:0] exp_rdata = '0;

  always @(posedge Clk) begin
    cyc++;
    if (!Rst) begin
      exp_ack = 0; exp_err = 0; exp_rdata = '0;
      pending = 0; next_accept = cyc + 1;
    end else begin
      exp_ack = 0; exp_err = 0;
      if (pending && cyc == ack_edge) begin
        exp_ack = 1;
        exp_err = pend_mis;
        if (!pend_we && !pend_mis) exp_rdata = pend_data;
        pending = 0;
      end
      if (cyc >= next_accept && Cs) begin
        int idx;
        idx = int'(Addr[11:2]);
`ifdef MISALIGN_ERR_EN
        pend_mis = (Addr[1:0] != 2'b00);
`else
        pend_mis = 0;
`endif
        pend_we = We;
        if (We && !pend_mis) model_mem[idx] = Wdata;
        if (!We) pend_data = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxxxxxx;
        ack_edge = cyc + LAT;
        next_accept = cyc + LAT + 2;
        pending = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (started) begin
      checkOutput("ack_model", {31'd0, Ack}, {31'd0, exp_ack});
      checkOutput("rdata_model", Rdata, exp_rdata);
`ifdef MISALIGN_ERR_EN
      checkOutput("err_model", {31'd0, Err}, {31'd0, exp_err});
`endif
    end
  end

  task automatic waitAck(output int edges, output logic [31:0] rd, output logic er);
    bit got;
    got = 0;
    edges = 0;
    while (!got && edges < 30) begin
      @(posedge Clk); #1;
      edges++;
      if (Ack) got = 1;
    end
    checkOutput("ack_seen", {31'd0, got}, 32'd1);
    rd = Rdata;
`ifdef MISALIGN_ERR_EN
    er = Err;
`else
    er = 1'b0;
`endif
  endtask

  task automatic applyStimulus(input logic we, input logic [11:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd,
                               output int edges, output logic er);
    @(negedge Clk);
    Cs = 1; We = we; Addr = addr; Wdata = wd;
    waitAck(edges, rd, er);
    @(negedge Clk);
    Cs = 0; We = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int e;
    int ackc;

    Rst = 0; Cs = 0; We = 0; Addr = '0; Wdata = '0;
    repeat (2) @(posedge Clk);
    #1;
    started = 1;
    checkOutput("reset_ack", {31'd0, Ack}, 32'd0);
    checkOutput("reset_rdata", Rdata, 32'd0);
    @(negedge Clk) Rst = 1;

    $display("[TB] reset behaviour");
    applyStimulus(1, 12'h008, 32'haaaa5555, rd, e, er);
    @(negedge Clk);
    Rst = 0; Cs = 1; We = 1; Addr = 12'h008; Wdata = 32'hbad0bad0;
    repeat (2) begin
      @(posedge Clk); #1;
      checkOutput("rst_hold_ack", {31'd0, Ack}, 32'd0);
      checkOutput("rst_hold_rdata", Rdata, 32'd0);
    end
    @(negedge Clk);
    Rst = 1; Addr = 12'h010; Wdata = 32'h01010101;
    waitAck(e, rd, er);
    checkOutput("first_accept_latency", e, 32'd3);
    @(negedge Clk);
    Cs = 0; We = 0;
    applyStimulus(0, 12'h008, '0, rd, e, er);
    checkOutput("no_write_in_reset", rd, 32'haaaa5555);
    applyStimulus(0, 12'h010, '0, rd, e, er);
    checkOutput("rd_after_release", rd, 32'h01010101);

    $display("[TB] latency and read-after-write");
    applyStimulus(1, 12'h07c, 32'hfffff000, rd, e, er);
    checkOutput("wr_latency", e, 32'd3);
    checkOutput("wr_keeps_rdata", rd, 32'h01010101);
    applyStimulus(0, 12'h07c, '0, rd, e, er);
    checkOutput("rd_latency", e, 32'd3);
    checkOutput("rd_07c", rd, 32'hfffff000);

    $display("[TB] top word");
    applyStimulus(1, 12'h000, 32'h13579bdf, rd, e, er);
    applyStimulus(1, 12'hffc, 32'h00000fff, rd, e, er);
    applyStimulus(0, 12'hffc, '0, rd, e, er);
    checkOutput("rd_top", rd, 32'h00000fff);
    applyStimulus(0, 12'h000, '0, rd, e, er);
    checkOutput("rd_word0", rd, 32'h13579bdf);

    $display("[TB] continuous Cs");
    ackc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Cs = 1; We = 1; Addr = 12'(12'h200 + 4 * i); Wdata = 32'hc0de0000 + 32'(i);
      @(posedge Clk); #1;
      if (Ack) ackc++;
    end
    @(negedge Clk);
    Cs = 0; We = 0;
    checkOutput("stream_ack_count", ackc, 32'd5);
    applyStimulus(0, 12'h210, '0, rd, e, er);
    checkOutput("stream_word_4", rd, 32'hc0de0004);
    applyStimulus(0, 12'h240, '0, rd, e, er);
    checkOutput("stream_word_16", rd, 32'hc0de0010);

    $display("[TB] reset mid-transaction");
    @(negedge Clk);
    Cs = 1; We = 1; Addr = 12'h300; Wdata = 32'hdeadbeef;
    @(negedge Clk);
    Rst = 0; Cs = 0; We = 0;
    @(negedge Clk);
    Rst = 1;
    ackc = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (Ack) ackc++;
    end
    checkOutput("mid_reset_no_ack", ackc, 32'd0);
    applyStimulus(0, 12'h300, '0, rd, e, er);
    checkOutput("mid_reset_committed", rd, 32'hdeadbeef);

`ifdef MISALIGN_ERR_EN
    $display("[TB] misaligned access");
    applyStimulus(1, 12'h080, 32'h0badf00d, rd, e, er);
    checkOutput("aligned_err", {31'd0, er}, 32'd0);
    applyStimulus(1, 12'h081, 32'h12345678, rd, e, er);
    checkOutput("misaligned_err", {31'd0, er}, 32'd1);
    checkOutput("misaligned_latency", e, 32'd3);
    applyStimulus(0, 12'h080, '0, rd, e, er);
    checkOutput("misaligned_no_write", rd, 32'h0badf00d);
    checkOutput("aligned_read_err", {31'd0, er}, 32'd0);
`endif

    repeat (3) @(posedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
